fft16_frame_ctrl: RTL and testbench

- Frame sequencer for the 16-point radix-2 DIF FFT stage chain: fft_stage1 through fft_stage4, registered externally.
- Collects 16 serial complex samples into a frame buffer and presents them as a flat bus to the first stage.
- Waits out the pipeline latency, captures the 16 results, then drains them serially with a valid/ready handshake.
- Sits between the sample-input interface and the top-level output port of the FFT core.

---
 rtl/fft_pkg.sv | 21 ++
 rtl/fft16_frame_ctrl_if.sv | 24 ++
 rtl/fft_frame_buf.sv | 31 +++
 rtl/fft16_frame_ctrl.sv | 128 ++++++++++++
 tb/tb_fft16_frame_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the 16-point FFT frame controller slice.
// Sample packing: real in the upper half, imag in the lower half.
package fft_pkg;

    localparam int N_PT     = 16;
    localparam int SAMPLE_W = 32;
    localparam int HALF_W   = 16;
    localparam int IDX_W    = 4;
    localparam int BUS_W    = N_PT * SAMPLE_W;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        CALC  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic logic [IDX_W-1:0] bitrev4(input logic [IDX_W-1:0] i);
        return {i[0], i[1], i[2], i[3]};
    endfunction

endpackage

// File: rtl/fft16_frame_ctrl_if.sv
// Sample-in / result-out handshake bundle of the FFT frame controller.
// master = controller side, slave = sample source and result sink.
interface fft16_frame_ctrl_if;
    import fft_pkg::*;

    logic                in_valid;
    logic [SAMPLE_W-1:0] in_data;
    logic                in_ready;
    logic                out_valid;
    logic                out_ready;
    logic [SAMPLE_W-1:0] out_data;
    logic [IDX_W-1:0]    out_idx;

    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx
    );

    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx
    );

endinterface

// File: rtl/fft_frame_buf.sv
// 16x32 register file: serial write port, parallel load, flat 512-bit read.
// Latency: writes/loads visible one cycle later; parallel load wins over a write.
// Backpressure: none, always accepts.
module fft_frame_buf
    import fft_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_addr,
    input  logic [SAMPLE_W-1:0] wr_dat,
    input  logic                ld_en,
    input  logic [BUS_W-1:0]    ld_bus,
    output logic [BUS_W-1:0]    rd_bus
);

    logic [N_PT-1:0][SAMPLE_W-1:0] mem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem <= '0;
        end else if (ld_en) begin
            mem <= ld_bus;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_bus = mem;

endmodule

// File: rtl/fft16_frame_ctrl.sv
// Frame sequencer for the 16-pt DIF FFT chain: fill 16 samples, wait STAGE_LAT, drain results.
// Latency: 16th sample at edge T -> frame_go in T+1 -> first out_valid in T+1+STAGE_LAT.
// Backpressure: in_ready low outside FILL; out_ready low stalls DRAIN. Option: FFT_BITREV_REORDER_EN.
module fft16_frame_ctrl
    import fft_pkg::*;
#(
    parameter int STAGE_LAT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    fft16_frame_ctrl_if.master    io,
    output logic [BUS_W-1:0]      frame_bus,
    output logic                  frame_go,
    input  logic [BUS_W-1:0]      res_bus,
    output logic                  busy
);

    localparam logic [IDX_W-1:0] LAT_LAST = IDX_W'(STAGE_LAT - 1);
    localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(N_PT - 1);

    state_t           state;
    logic [IDX_W-1:0] wr_cnt;
    logic [IDX_W-1:0] lat_cnt;
    logic [IDX_W-1:0] rd_cnt;
    logic             in_rdy_q;
    logic             out_vld_q;
    logic             wr_fire;
    logic             rd_fire;
    logic             cap_en;
    logic [IDX_W-1:0] sel_idx;
    logic [BUS_W-1:0] res_q;

    assign wr_fire = io.in_valid & in_rdy_q & (state == FILL);
    assign rd_fire = out_vld_q & io.out_ready;
    assign cap_en  = (state == CALC) && (lat_cnt == LAT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FILL;
            wr_cnt    <= '0;
            lat_cnt   <= '0;
            rd_cnt    <= '0;
            in_rdy_q  <= 1'b0;
            out_vld_q <= 1'b0;
            frame_go  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    in_rdy_q <= 1'b1;
                    if (wr_fire) begin
                        if (wr_cnt == CNT_LAST) begin
                            state    <= CALC;
                            wr_cnt   <= '0;
                            lat_cnt  <= '0;
                            in_rdy_q <= 1'b0;
                            frame_go <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                CALC: begin
                    frame_go <= 1'b0;
                    if (cap_en) begin
                        state     <= DRAIN;
                        lat_cnt   <= '0;
                        out_vld_q <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (rd_fire) begin
                        if (rd_cnt == CNT_LAST) begin
                            state     <= FILL;
                            rd_cnt    <= '0;
                            out_vld_q <= 1'b0;
                            busy      <= 1'b0;
                            in_rdy_q  <= 1'b1;
                        end else begin
                            rd_cnt <= rd_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

    fft_frame_buf u_in_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_fire),
        .wr_addr (wr_cnt),
        .wr_dat  (io.in_data),
        .ld_en   (1'b0),
        .ld_bus  ({BUS_W{1'b0}}),
        .rd_bus  (frame_bus)
    );

    fft_frame_buf u_res_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (1'b0),
        .wr_addr ({IDX_W{1'b0}}),
        .wr_dat  ({SAMPLE_W{1'b0}}),
        .ld_en   (cap_en),
        .ld_bus  (res_bus),
        .rd_bus  (res_q)
    );

    // DIF results sit in bit-reversed order; optionally undo that on the way out.
`ifdef FFT_BITREV_REORDER_EN
    assign sel_idx = bitrev4(rd_cnt);
`else
    assign sel_idx = rd_cnt;
`endif

    assign io.in_ready  = in_rdy_q;
    assign io.out_valid = out_vld_q;
    assign io.out_idx   = rd_cnt;
    assign io.out_data  = res_q[{sel_idx, 5'd0} +: SAMPLE_W];

endmodule

// File: tb/tb_fft16_frame_ctrl.sv
// Directed bench for fft16_frame_ctrl with a stub res_bus (index ramp or impulse replica).
module tb_fft16_frame_ctrl;
    import fft_pkg::*;

    localparam int LAT = 4;

    typedef struct {
        logic [31:0] in_dat;
        logic [3:0]  exp_idx;
        logic [31:0] exp_out;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [BUS_W-1:0] frame_bus;
    logic             frame_go;
    logic [BUS_W-1:0] res_bus;
    logic             busy;
    logic             impulse_mode = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int go_cnt = 0;
    vec_t vt[16];

`ifdef FFT_BITREV_REORDER_EN
    logic [3:0] ord[16] = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
                            4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};
`else
    logic [3:0] ord[16] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                            4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
`endif

    fft16_frame_ctrl_if io ();

    fft16_frame_ctrl #(.STAGE_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .io        (io.master),
        .frame_bus (frame_bus),
        .frame_go  (frame_go),
        .res_bus   (res_bus),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Stub for the stage chain: ramp of slot indices, or an impulse replicated to every bin.
    always_comb begin
        res_bus = '0;
        for (int k = 0; k < N_PT; k++) begin
            res_bus[32*k +: 32] = impulse_mode ? frame_bus[31:0] : 32'(k);
        end
    end

    always @(negedge clk) begin
        if (rst && frame_go) go_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] sample_of(input int k, input logic imp);
        if (imp) return (k == 0) ? 32'h0001_0000 : 32'h0;
        return vt[k].in_dat;
    endfunction

    // Stream one frame starting at a negedge; optional 3-cycle in_valid gap before sample 5.
    task automatic feed(input logic imp, input logic gap);
        int guard;
        for (int k = 0; k < N_PT; k++) begin
            if (gap && k == 5) begin
                io.in_valid = 1'b0;
                repeat (3) @(negedge clk);
            end
            io.in_valid = 1'b1;
            io.in_data  = sample_of(k, imp);
            guard = 0;
            while (!io.in_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) chk("in_ready_timeout", 32'(guard), 32'd0);
            @(negedge clk);
        end
        io.in_valid = 1'b0;
        chk("frame_go_pulse", 32'(frame_go), 32'd1);
        chk("busy_calc", 32'(busy), 32'd1);
        chk("in_ready_calc", 32'(io.in_ready), 32'd0);
        for (int k = 0; k < N_PT; k++) begin
            chk($sformatf("frame_bus_slot%0d", k), frame_bus[32*k +: 32], sample_of(k, imp));
        end
    endtask

    // Count cycles from the frame_go cycle to out_valid; optionally present a bogus sample meanwhile.
    task automatic wait_lat(input logic inject);
        int c = 0;
        if (inject) begin
            io.in_valid = 1'b1;
            io.in_data  = 32'hDEAD_BEEF;
        end
        while (!io.out_valid && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("first_out_latency", 32'(c), 32'(LAT));
    endtask

    // Drain from a negedge; stall 3 cycles before transfer stall_at, stop after stop_at transfers.
    task automatic drain(input logic imp, input int stall_at, input int stop_at);
        int guard;
        for (int i = 0; i < stop_at; i++) begin
            guard = 0;
            while (!io.out_valid && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) chk("out_valid_timeout", 32'(guard), 32'd0);
            chk($sformatf("out_idx_%0d", i), 32'(io.out_idx), 32'(vt[i].exp_idx));
            chk($sformatf("out_data_%0d", i), io.out_data, imp ? 32'h0001_0000 : vt[i].exp_out);
            chk("in_ready_drain", 32'(io.in_ready), 32'd0);
            if (i == stall_at) begin
                io.out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    chk("stall_valid", 32'(io.out_valid), 32'd1);
                    chk("stall_idx", 32'(io.out_idx), 32'(vt[i].exp_idx));
                    chk("stall_data", io.out_data, imp ? 32'h0001_0000 : vt[i].exp_out);
                end
                io.out_ready = 1'b1;
            end
            @(negedge clk);
        end
        io.in_valid = 1'b0;
        if (stop_at == N_PT) begin
            chk("drain_done_valid", 32'(io.out_valid), 32'd0);
            chk("drain_done_busy", 32'(busy), 32'd0);
            chk("drain_done_in_ready", 32'(io.in_ready), 32'd1);
        end
    endtask

    initial begin
        for (int k = 0; k < N_PT; k++) begin
            vt[k].in_dat  = 32'hA500_0000 + 32'(k) * 32'h0003_0101;
            vt[k].exp_idx = 4'(k);
            vt[k].exp_out = 32'(ord[k]);
        end
        io.in_valid  = 1'b0;
        io.in_data   = '0;
        io.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(io.in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(io.out_valid), 32'd0);
        chk("rst_frame_go", 32'(frame_go), 32'd0);
        chk("rst_out_data", io.out_data, 32'd0);
        chk("rst_out_idx", 32'(io.out_idx), 32'd0);
        chk("rst_frame_bus", 32'(|frame_bus), 32'd0);
        rst = 1'b1;
        chk("rel_in_ready_before_edge", 32'(io.in_ready), 32'd0);
        @(negedge clk);
        chk("rel_in_ready", 32'(io.in_ready), 32'd1);
        chk("rel_busy", 32'(busy), 32'd0);

        // Frame 1: ramp stub, bogus input during CALC/DRAIN, stall at rd_cnt=5.
        feed(1'b0, 1'b0);
        wait_lat(1'b1);
        chk("go_once_f1", 32'(go_cnt), 32'd1);
        drain(1'b0, 5, N_PT);

        // Frame 2: impulse with in_valid gaps; bogus sample must not have leaked in.
        impulse_mode = 1'b1;
        feed(1'b1, 1'b1);
        for (int k = 0; k < N_PT; k++) begin
            if (frame_bus[32*k +: 32] == 32'hDEAD_BEEF) chk("no_stale_sample", 32'(k), 32'hFFFF_FFFF);
        end
        wait_lat(1'b0);
        chk("go_once_f2", 32'(go_cnt), 32'd2);
        drain(1'b1, -1, N_PT);

        // Frame 3: reset mid-DRAIN at rd_cnt=7.
        impulse_mode = 1'b0;
        feed(1'b0, 1'b0);
        wait_lat(1'b0);
        drain(1'b0, -1, 7);
        chk("pre_rst_idx", 32'(io.out_idx), 32'd7);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(io.out_valid), 32'd0);
        chk("midrst_out_idx", 32'(io.out_idx), 32'd0);
        chk("midrst_out_data", io.out_data, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(io.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rerel_in_ready", 32'(io.in_ready), 32'd1);
        chk("rerel_busy", 32'(busy), 32'd0);

        // Frame 4: fresh frame after the abort.
        go_cnt = 0;
        feed(1'b0, 1'b0);
        wait_lat(1'b0);
        chk("go_once_f4", 32'(go_cnt), 32'd1);
        drain(1'b0, -1, N_PT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
